// File: rtl/decoder_scan_n_if.sv
// Bus bundle for decoder_scan_n: control/handshake inputs and registered decode outputs.
// master drives the controls; slave is the decoder itself.
interface decoder_scan_n_if #(
    parameter int SEL_W   = 2,
    parameter int DWELL_W = 8
);
    localparam int OUT_W = 1 << SEL_W;

    logic               enable_i;
    logic               mode_i;
    logic               d_valid_i;
    logic               d_ready_o;
    logic [SEL_W-1:0]   d_in_i;
    logic [DWELL_W-1:0] dwell_i;
    logic [OUT_W-1:0]   y_out_o;
    logic [SEL_W-1:0]   sel_out_o;
    logic               wrap_o;

    modport master (
        output enable_i, mode_i, d_valid_i, d_in_i, dwell_i,
        input  d_ready_o, y_out_o, sel_out_o, wrap_o
    );

    modport slave (
        input  enable_i, mode_i, d_valid_i, d_in_i, dwell_i,
        output d_ready_o, y_out_o, sel_out_o, wrap_o
    );
endinterface

// File: rtl/decoder_scan_n.sv
// Registered N-to-2^N one-hot decoder with a handshaked direct mode and a
// walking-one scan mode whose per-position hold time is programmable.
module decoder_scan_n #(
    parameter int SEL_W   = 2,
    parameter int DWELL_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    decoder_scan_n_if.slave  bus
);
    localparam int OUT_W = 1 << SEL_W;

    typedef enum logic [1:0] {
        IDLE,
        DIRECT,
        SCAN
    } state_t;

    state_t             state_q, state_d;
    logic [OUT_W-1:0]   y_q, y_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               wrap_q, wrap_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0]   selInc;

    // In scan mode sel_q doubles as the scan index; its natural wrap is modulo OUT_W.
    assign selInc = sel_q + SEL_W'(1);

    always_comb begin
        state_d = IDLE;
        y_d     = y_q;
        sel_d   = sel_q;
        wrap_d  = 1'b0;
        cnt_d   = cnt_q;
        if (bus.enable_i) begin
            state_d = bus.mode_i ? SCAN : DIRECT;
        end
        case (state_d)
            DIRECT: begin
                cnt_d = '0;
                if (state_q != DIRECT) begin
                    y_d   = '0;
                    sel_d = '0;
                end else if (bus.d_valid_i) begin
                    y_d   = OUT_W'(1) << bus.d_in_i;
                    sel_d = bus.d_in_i;
                end
            end
            SCAN: begin
                if (state_q != SCAN) begin
                    y_d   = OUT_W'(1);
                    sel_d = '0;
                    cnt_d = bus.dwell_i;
                end else if (cnt_q == '0) begin
                    y_d    = OUT_W'(1) << selInc;
                    sel_d  = selInc;
                    cnt_d  = bus.dwell_i;
                    wrap_d = (selInc == '0);
                end else begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end
            end
            default: begin
                y_d   = '0;
                sel_d = '0;
                cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            y_q     <= '0;
            sel_q   <= '0;
            wrap_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            sel_q   <= sel_d;
            wrap_q  <= wrap_d;
            cnt_q   <= cnt_d;
        end
    end

    // d_ready comes from the state register alone, so it lags DIRECT entry by a cycle.
    assign bus.d_ready_o = (state_q == DIRECT);
    assign bus.y_out_o   = y_q;
    assign bus.sel_out_o = sel_q;
    assign bus.wrap_o    = wrap_q;
endmodule

// File: tb/tb_decoder_scan_n.sv
// Scoreboard bench for decoder_scan_n: a position/hold-time model predicts every
// cycle's outputs, and a separate monitor compares them against the DUT.
module tb_decoder_scan_n;
    localparam int SEL_W   = 2;
    localparam int DWELL_W = 8;
    localparam int OUT_W   = 1 << SEL_W;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    decoder_scan_n_if #(.SEL_W(SEL_W), .DWELL_W(DWELL_W)) bus ();

    decoder_scan_n #(.SEL_W(SEL_W), .DWELL_W(DWELL_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Expected word layout: {y_out, sel_out, wrap, d_ready}.
    logic [7:0] expQ[$];

    // Model: which mode we are in, which output is lit, how long it has been lit
    // and how long it is meant to stay lit.
    int mMode;
    int mPos;
    int mHeld;
    int mHold;
    int mY;
    int mSel;
    int mWrap;

    int cyc         = 0;
    int lastWrapCyc = -1;
    int lastPeriod  = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic resetModel();
        mMode = 0;
        mPos  = 0;
        mHeld = 0;
        mHold = 1;
        mY    = 0;
        mSel  = 0;
        mWrap = 0;
    endtask

    task automatic modelStep(input bit en, input bit md, input bit dv, input int din, input int dw);
        mWrap = 0;
        if (!en) begin
            mMode = 0;
            mY    = 0;
            mSel  = 0;
        end else if (!md) begin
            if (mMode != 1) begin
                mY   = 0;
                mSel = 0;
            end else if (dv) begin
                mY   = 1 << din;
                mSel = din;
            end
            mMode = 1;
        end else begin
            if (mMode != 2) begin
                mPos  = 0;
                mHeld = 0;
                mHold = dw + 1;
            end else begin
                mHeld++;
                if (mHeld == mHold) begin
                    mPos  = (mPos + 1) % OUT_W;
                    mHeld = 0;
                    mHold = dw + 1;
                    mWrap = (mPos == 0);
                end
            end
            mY    = 1 << mPos;
            mSel  = mPos;
            mMode = 2;
        end
    endtask

    task automatic applyStimulus(input bit en, input bit md, input bit dv, input int din,
                                 input int dw, input int n);
        logic [3:0] yv;
        logic [1:0] sv;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            bus.enable_i  = en;
            bus.mode_i    = md;
            bus.d_valid_i = dv;
            bus.d_in_i    = SEL_W'(din);
            bus.dwell_i   = DWELL_W'(dw);
            modelStep(en, md, dv, din, dw);
            yv = 4'(mY);
            sv = 2'(mSel);
            expQ.push_back({yv, sv, mWrap[0], (mMode == 1)});
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 10 && expQ.size() > 0; k++) begin
            @(posedge clk);
            #2;
        end
        checkOutput("drain", expQ.size(), 0);
    endtask

    initial begin : monitor
        logic [7:0] e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.wrap_o) begin
                if (lastWrapCyc >= 0) lastPeriod = cyc - lastWrapCyc;
                lastWrapCyc = cyc;
            end
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("scoreboard",
                            {bus.y_out_o, bus.sel_out_o, bus.wrap_o, bus.d_ready_o}, e);
            end
        end
    end

    initial begin : stimulus
        bit curMode;
        rst_n         = 1'b0;
        bus.enable_i  = 1'b0;
        bus.mode_i    = 1'b0;
        bus.d_valid_i = 1'b0;
        bus.d_in_i    = '0;
        bus.dwell_i   = '0;
        resetModel();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Asynchronous reset in the middle of a scan.
        applyStimulus(1, 1, 0, 0, 1, 5);
        drain();
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("asyncReset", {bus.y_out_o, bus.sel_out_o, bus.wrap_o, bus.d_ready_o}, 8'h00);
        resetModel();
        @(negedge clk);
        bus.enable_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, 1, 0, 0, 1, 3);

        // Direct decode, including a d_valid offered in the entry cycle.
        applyStimulus(1, 0, 1, 2, 0, 1);
        for (int i = 0; i < OUT_W; i++) applyStimulus(1, 0, 1, i, 0, 1);
        applyStimulus(1, 0, 0, 1, 0, 2);
        drain();
        checkOutput("directHold", bus.y_out_o, 4'b1000);

        // Scan with dwell=2 over three laps.
        lastWrapCyc = -1;
        lastPeriod  = 0;
        applyStimulus(1, 1, 0, 0, 2, 40);
        drain();
        checkOutput("scanPeriod", lastPeriod, 12);

        // dwell=0, then dwell 0->3 while position 1 is lit.
        lastWrapCyc = -1;
        lastPeriod  = 0;
        applyStimulus(1, 1, 0, 0, 0, 9);
        drain();
        checkOutput("fastPeriod", lastPeriod, 4);
        for (int k = 0; k < 8 && mPos != 1; k++) applyStimulus(1, 1, 0, 0, 0, 1);
        applyStimulus(1, 1, 0, 0, 3, 12);

        // Mode switch from position 2 to direct and back.
        for (int k = 0; k < 40 && mPos != 2; k++) applyStimulus(1, 1, 0, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 0, 2);
        applyStimulus(1, 0, 1, 3, 0, 1);
        applyStimulus(1, 0, 0, 0, 0, 1);
        applyStimulus(1, 1, 1, 2, 0, 3);

        // Disable while position 1 is lit, then re-enable the scan.
        for (int k = 0; k < 8 && mPos != 1; k++) applyStimulus(1, 1, 0, 0, 0, 1);
        applyStimulus(0, 1, 0, 0, 0, 1);
        applyStimulus(1, 1, 0, 0, 1, 6);

        // Randomised traffic with occasional mode flips and disables.
        curMode = 1'b0;
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 15) == 0) curMode = ~curMode;
            applyStimulus(($urandom_range(0, 19) != 0), curMode, 1'($urandom_range(0, 1)),
                          int'($urandom_range(0, OUT_W - 1)), int'($urandom_range(0, 3)), 1);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
